serial_subtractor: RTL and testbench

Bit-serial, LSB-first subtractor computing `a - b - bin` over `WIDTH` clock cycles using one shared full-subtractor cell. It is the sequential subtract counterpart to the team's combinational ripple adders. It trades latency for area in datapaths where a full-width subtract path is not justified. Operands are captured with a start pulse, and the result is presented with a one-cycle done pulse and held until the next result.

---
 rtl/arith_pkg.sv | 14 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package.
//   sub_state_t : control states of the bit-serial subtractor
//   ARITH_WIDTH : default operand width for the serial arithmetic blocks
package arith_pkg;

    localparam int ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, computing a - b - bin.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   diff      : difference bit
//   bout      : borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a, or when a == b and a borrow is still pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor: diff = (a - b - bin) mod 2^WIDTH over
// WIDTH cycles through a single full-subtractor cell.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : capture a/b/bin; honoured in IDLE or DONE only
//   a, b, bin  : unsigned minuend, subtrahend, borrow-in
//   busy       : high while bits are being processed
//   done       : one-cycle pulse in the cycle diff/bout are updated
//   diff, bout : registered result and final borrow, held until next result
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;

    logic             fs_d, fs_bo;
    logic             accept, last_bit;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (brw_q),
        .diff (fs_d),
        .bout (fs_bo)
    );

    assign accept    = start && (state_q != BUSY);
    assign last_bit  = (state_q == BUSY) && (cnt_q == CW'(WIDTH - 1));
    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign res_shift = {fs_d, res_q[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = BUSY;
            BUSY:    if (last_bit) state_d = DONE;
            DONE:    state_d = start ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state: busy and done are mutually exclusive, so a
    // back-to-back start shows one DONE cycle between the two BUSY runs.
    always_comb begin
        busy = (state_q == BUSY);
        done = (state_q == DONE);
    end

    // Datapath next values
    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        res_d  = res_q;
        cnt_d  = cnt_q;
        brw_d  = brw_q;
        diff_d = diff_q;
        bout_d = bout_q;
        if (accept) begin
            sa_d  = a;
            sb_d  = b;
            brw_d = bin;
            cnt_d = '0;
            res_d = '0;
        end else if (state_q == BUSY) begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            brw_d = fs_bo;
            cnt_d = cnt_q + CW'(1);
            res_d = res_shift;
            if (last_bit) begin
                diff_d = res_shift;
                bout_d = fs_bo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
            brw_q  <= brw_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bout4;
    logic [3:0] diff4;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    // Drives start for one edge from a negedge and returns at the negedge
    // where done is seen; lat = edges after the start edge.
    task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                       output logic [3:0] od, output logic ob, output int lat);
        a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        od = diff4; ob = bout4;
        if (lat >= 20) begin
            checks++; errors++;
            $display("FAIL op4_timeout a=%0d b=%0d bin=%0d no done within 20 cycles", ia, ib, ibin);
        end
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                       output logic [7:0] od, output logic ob, output int lat);
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        od = diff8; ob = bout8;
        if (lat >= 30) begin
            checks++; errors++;
            $display("FAIL op8_timeout a=%0d b=%0d bin=%0d no done within 30 cycles", ia, ib, ibin);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b diff=%h bout=%b want all 0",
                     busy4, done4, diff4, bout4);
        end
        checks++;
        if ({busy8, done8, diff8, bout8} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs8 got busy=%b done=%b diff=%h bout=%b want all 0",
                     busy8, done8, diff8, bout8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // 9 - 3: check busy/done timing cycle by cycle.
    task automatic test_basic();
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            start4 = 1'b0;
            checks++;
            if (busy4 !== (i < 4) || done4 !== (i == 4)) begin
                errors++;
                $display("FAIL basic_timing edge=%0d got busy=%b done=%b want busy=%b done=%b",
                         i, busy4, done4, i < 4, i == 4);
            end
            if (i < 4) begin
                checks++;
                if (diff4 !== 4'h0) begin
                    errors++;
                    $display("FAIL basic_hold edge=%0d got diff=%h want 0", i, diff4);
                end
            end
            if (i == 4) begin
                checks++;
                if (diff4 !== 4'h6 || bout4 !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_9m3 got diff=%h bout=%b want diff=6 bout=0", diff4, bout4);
                end
            end
        end
    endtask

    task automatic test_vectors();
        logic [3:0] d; logic bo; int lat;
        logic [3:0] va [3] = '{4'd3, 4'd0, 4'd15};
        logic [3:0] vb [3] = '{4'd9, 4'd0, 4'd15};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [3:0] ed [3] = '{4'hA, 4'hF, 4'h0};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            op4(va[k], vb[k], vc[k], d, bo, lat);
            checks++;
            if (d !== ed[k] || bo !== eb[k] || lat != 4) begin
                errors++;
                $display("FAIL vector_%0d got diff=%h bout=%b lat=%0d want diff=%h bout=%b lat=4",
                         k, d, bo, lat, ed[k], eb[k]);
            end
            @(negedge clk);
        end
    endtask

    // Second start two cycles into BUSY must be ignored.
    task automatic test_start_ignored();
        logic [3:0] prev;
        int ndone;
        prev = diff4;
        ndone = 0;
        a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            start4 = (i == 1);
            if (i == 1) begin a4 = 4'd1; b4 = 4'd1; end
            if (i < 4) begin
                checks++;
                if (diff4 !== prev || busy4 !== 1'b1) begin
                    errors++;
                    $display("FAIL ignore_busy_hold edge=%0d got diff=%h busy=%b want diff=%h busy=1",
                             i, diff4, busy4, prev);
                end
            end
            if (done4) begin
                ndone++;
                checks++;
                if (diff4 !== 4'd5 || i != 4) begin
                    errors++;
                    $display("FAIL ignore_result edge=%0d got diff=%h want diff=5 at edge 4", i, diff4);
                end
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ignore_single_done got %0d done pulses want 1", ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d; logic bo; int lat;
        op4(4'd7, 4'd2, 1'b0, d, bo, lat);
        checks++;
        if (d !== 4'd5 || busy4 !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL b2b_first got diff=%h busy=%b lat=%0d want diff=5 busy=0 lat=4", d, busy4, lat);
        end
        // Start presented in the DONE cycle.
        a4 = 4'd12; b4 = 4'd5; bin4 = 1'b0; start4 = 1'b1;
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (j < 4) begin
                checks++;
                if (busy4 !== 1'b1 || done4 !== 1'b0 || diff4 !== 4'd5) begin
                    errors++;
                    $display("FAIL b2b_busy edge=%0d got busy=%b done=%b diff=%h want busy=1 done=0 diff=5",
                             j, busy4, done4, diff4);
                end
            end else begin
                checks++;
                if (done4 !== 1'b1 || diff4 !== 4'd7 || bout4 !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second got done=%b diff=%h bout=%b want done=1 diff=7 bout=0",
                             done4, diff4, bout4);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [3:0] d; logic bo; int lat; int ndone;
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy4, done4, diff4, bout4} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs got busy=%b done=%b diff=%h bout=%b want all 0",
                     busy4, done4, diff4, bout4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d active cycles after release want 0", ndone);
        end
        op4(4'd6, 4'd1, 1'b0, d, bo, lat);
        checks++;
        if (d !== 4'd5 || bo !== 1'b0 || lat != 4) begin
            errors++;
            $display("FAIL midreset_after got diff=%h bout=%b lat=%0d want diff=5 bout=0 lat=4", d, bo, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive4();
        logic [3:0] d; logic bo; int lat;
        logic [4:0] exp5;
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    op4(4'(ia), 4'(ib), 1'(ic), d, bo, lat);
                    exp5 = 5'(ia - ib - ic);
                    checks++;
                    if ({bo, d} !== exp5 || lat != 4) begin
                        errors++;
                        $display("FAIL exhaustive4 a=%0d b=%0d bin=%0d got %b_%h lat=%0d want %b_%h lat=4",
                                 ia, ib, ic, bo, d, lat, exp5[4], exp5[3:0]);
                    end
                end
        @(negedge clk);
    endtask

    task automatic test_random8();
        logic [7:0] d, ra, rb; logic bo, rc; int lat;
        logic [8:0] exp9;
        for (int n = 0; n < 2000; n++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            op8(ra, rb, rc, d, bo, lat);
            exp9 = {1'b0, ra} - {1'b0, rb} - {8'b0, rc};
            checks++;
            if ({bo, d} !== exp9 || lat != 8) begin
                errors++;
                $display("FAIL random8 a=%0d b=%0d bin=%0d got %b_%h lat=%0d want %b_%h lat=8",
                         ra, rb, rc, bo, d, lat, exp9[8], exp9[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive4();
        test_random8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
